// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter register and instruction-fetch request stage. Captures the
// NextPC chosen by the PC-source mux, drives the instruction-memory request,
// and hands accepted instructions to IF/ID with a one-cycle FetchValid pulse.
// Handles multi-cycle memory handshakes, hazard stalls and redirects.
//
// Parameters:
//   RESET_VECTOR  PC value loaded on reset
//   MAX_WAIT      FETCH cycles without ImemAck before ImemTimeout sets (1..255)
//
// Ports:
//   Clk          in   1   system clock, rising edge
//   Reset        in   1   asynchronous active-low reset
//   NextPC       in   32  next PC from the PC-source mux
//   Redirect     in   1   NextPC is a taken branch/jump target
//   Stall        in   1   hazard unit freezes fetch
//   ImemAck      in   1   memory returned the word at PCResult
//   PCResult     out  32  current PC / instruction-memory address
//   PCPlus4      out  32  PCResult + 4 (combinational, wraps mod 2^32)
//   PCUpper      out  4   PCPlus4[31:28] (combinational)
//   ImemReq      out  1   registered fetch request, high only in FETCH
//   FetchValid   out  1   registered one-cycle delivery pulse
//   FetchPC      out  32  PC of the instruction flagged by FetchValid
//   ImemTimeout  out  1   sticky watchdog flag
//   AlignErr     out  1   sticky misaligned-NextPC flag (only with the macro)
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   Defined: adds AlignErr and forces loaded PCs to word alignment.
//   Undefined: NextPC is loaded unmodified.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] NextPC,
    input  logic        Redirect,
    input  logic        Stall,
    input  logic        ImemAck,
    output logic [31:0] PCResult,
    output logic [31:0] PCPlus4,
    output logic [3:0]  PCUpper,
    output logic        ImemReq,
    output logic        FetchValid,
    output logic [31:0] FetchPC,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        ImemTimeout,
    output logic        AlignErr
`else
    output logic        ImemTimeout
`endif
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        CANCEL = 2'd3
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // Saturating increment of the wait counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        logic [7:0] res;
        if (cnt >= MAX_WAIT_C) begin
            res = MAX_WAIT_C;
        end else begin
            res = cnt + 8'd1;
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] fetch_pc_r;
    logic        fetch_valid_r;
    logic        imem_req_r;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_next_s;
    logic        timeout_r;
    logic        pc_load_s;
    logic        deliver_s;
    logic [31:0] pc_load_value_s;

`ifdef PC_MISALIGN_TRAP_EN
    logic        align_err_r;
    logic        misalign_s;

    // Word-align the loaded PC and flag any PC update carrying low bits.
    always_comb begin
        pc_load_value_s = {NextPC[31:2], 2'b00};
        misalign_s      = pc_load_s && (NextPC[1:0] != 2'b00);
    end

    // Sticky alignment-error flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            align_err_r <= 1'b0;
        end else begin
            align_err_r <= align_err_r | misalign_s;
        end
    end

    assign AlignErr = align_err_r;
`else
    // NextPC is loaded unmodified when the alignment trap is not built.
    always_comb begin
        pc_load_value_s = NextPC;
    end
`endif

    // Next-state, PC-load, delivery and wait-counter decisions.
    always_comb begin
        state_next_s = state_r;
        pc_load_s    = 1'b0;
        deliver_s    = 1'b0;
        wait_next_s  = 8'd0;
        case (state_r)
            BOOT: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                // Redirect wins over stall and ack; a same-cycle ack is discarded.
                if (Redirect) begin
                    pc_load_s    = 1'b1;
                    state_next_s = CANCEL;
                end else if (ImemAck && !Stall) begin
                    deliver_s    = 1'b1;
                    pc_load_s    = 1'b1;
                    state_next_s = FETCH;
                end else if (ImemAck) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = FETCH;
                    wait_next_s  = sat_inc(wait_cnt_r);
                end
            end
            HOLD: begin
                if (Redirect) begin
                    pc_load_s    = 1'b1;
                    state_next_s = CANCEL;
                end else if (!Stall) begin
                    deliver_s    = 1'b1;
                    pc_load_s    = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = HOLD;
                end
            end
            CANCEL: begin
                // A further redirect keeps the request dropped one more cycle.
                if (Redirect) begin
                    pc_load_s    = 1'b1;
                    state_next_s = CANCEL;
                end else begin
                    state_next_s = FETCH;
                end
            end
            default: begin
                state_next_s = BOOT;
            end
        endcase
    end

    // State, request and delivery registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r       <= BOOT;
            imem_req_r    <= 1'b0;
            fetch_valid_r <= 1'b0;
            fetch_pc_r    <= RESET_VECTOR;
        end else begin
            state_r       <= state_next_s;
            imem_req_r    <= (state_next_s == FETCH);
            fetch_valid_r <= deliver_s;
            if (deliver_s) begin
                fetch_pc_r <= pc_r;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

    // Program counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_r <= RESET_VECTOR;
        end else if (pc_load_s) begin
            pc_r <= pc_load_value_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Wait counter and sticky watchdog flag; fetch continues after timeout.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            wait_cnt_r <= wait_next_s;
            timeout_r  <= timeout_r | (wait_next_s == MAX_WAIT_C);
        end
    end

    assign PCResult    = pc_r;
    assign PCPlus4     = pc_r + 32'd4;
    assign PCUpper     = PCPlus4[31:28];
    assign ImemReq     = imem_req_r;
    assign FetchValid  = fetch_valid_r;
    assign FetchPC     = fetch_pc_r;
    assign ImemTimeout = timeout_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit: a table of directed vectors with
// hand-derived expectations, hand-written watchdog / async-reset / wraparound
// sequences, then randomized traffic against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam int          MW = 15;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] NextPC = 32'd0;
    logic        Redirect = 1'b0;
    logic        Stall = 1'b0;
    logic        ImemAck = 1'b0;
    logic [31:0] PCResult;
    logic [31:0] PCPlus4;
    logic [3:0]  PCUpper;
    logic        ImemReq;
    logic        FetchValid;
    logic [31:0] FetchPC;
    logic        ImemTimeout;
`ifdef PC_MISALIGN_TRAP_EN
    logic        AlignErr;
`endif

    pc_fetch_unit #(.RESET_VECTOR(RV), .MAX_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .NextPC(NextPC), .Redirect(Redirect),
        .Stall(Stall), .ImemAck(ImemAck), .PCResult(PCResult),
        .PCPlus4(PCPlus4), .PCUpper(PCUpper), .ImemReq(ImemReq),
        .FetchValid(FetchValid), .FetchPC(FetchPC),
`ifdef PC_MISALIGN_TRAP_EN
        .ImemTimeout(ImemTimeout), .AlignErr(AlignErr)
`else
        .ImemTimeout(ImemTimeout)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The fetch stage is described by what the memory port is doing:
    // booting, waiting for an ack, holding an accepted word, or dropping
    // a stale request after a redirect.
    bit          m_booting, m_holding, m_dropping;
    logic [31:0] m_pc, m_fpc;
    bit          m_fv, m_to, m_ae;
    int          m_wait;

    function automatic logic [31:0] target(input logic [31:0] n);
`ifdef PC_MISALIGN_TRAP_EN
        return n & 32'hFFFF_FFFC;
`else
        return n;
`endif
    endfunction

    task automatic model_reset();
        m_booting = 1'b1; m_holding = 1'b0; m_dropping = 1'b0;
        m_pc = RV; m_fpc = RV; m_fv = 1'b0; m_to = 1'b0; m_ae = 1'b0; m_wait = 0;
    endtask

    task automatic jump(input logic [31:0] n);
        if (n[1:0] != 2'b00) m_ae = 1'b1;
        m_pc = target(n);
    endtask

    task automatic model_update(input logic r, input logic s, input logic a, input logic [31:0] n);
        m_fv = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_dropping) begin
            if (r) jump(n);
            else m_dropping = 1'b0;
        end else if (m_holding) begin
            if (r) begin
                jump(n); m_holding = 1'b0; m_dropping = 1'b1;
            end else if (!s) begin
                m_fpc = m_pc; m_fv = 1'b1; jump(n); m_holding = 1'b0;
            end
        end else begin
            if (r) begin
                jump(n); m_dropping = 1'b1; m_wait = 0;
            end else if (a && !s) begin
                m_fpc = m_pc; m_fv = 1'b1; jump(n); m_wait = 0;
            end else if (a) begin
                m_holding = 1'b1; m_wait = 0;
            end else begin
                m_wait = (m_wait < MW) ? m_wait + 1 : MW;
                if (m_wait == MW) m_to = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        bit req_exp;
        req_exp = !(m_booting || m_holding || m_dropping);
        chk("m_pc", PCResult, m_pc);
        chk("m_plus4", PCPlus4, m_pc + 32'd4);
        chk("m_upper", {28'd0, PCUpper}, {28'd0, 4'((m_pc + 32'd4) >> 28)});
        chk("m_req", {31'd0, ImemReq}, {31'd0, req_exp});
        chk("m_fv", {31'd0, FetchValid}, {31'd0, m_fv});
        chk("m_fpc", FetchPC, m_fpc);
        chk("m_timeout", {31'd0, ImemTimeout}, {31'd0, m_to});
`ifdef PC_MISALIGN_TRAP_EN
        chk("m_alignerr", {31'd0, AlignErr}, {31'd0, m_ae});
`endif
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic r, input logic s, input logic a, input logic [31:0] n);
        Redirect = r; Stall = s; ImemAck = a; NextPC = n;
        @(posedge Clk); #1;
        model_update(r, s, a, n);
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, PCResult, RV);
        chk({tag, "_fpc"}, FetchPC, RV);
        chk({tag, "_req"}, {31'd0, ImemReq}, 32'd0);
        chk({tag, "_fv"}, {31'd0, FetchValid}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, ImemTimeout}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
        chk({tag, "_alignerr"}, {31'd0, AlignErr}, 32'd0);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, s, a;
        logic [31:0] n;
        logic [31:0] pc;
        logic        req, fv;
        logic [31:0] fpc;
    } vec_t;

    localparam logic [31:0] JUNK = 32'hDEAD_BEE0;
    vec_t tbl[23];

    initial begin
        //          r     s     a     NextPC        PC            req   fv    FetchPC
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0004, 32'h0040_0000, 1'b1, 1'b0, 32'h0040_0000}; // boot
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0004, 32'h0040_0004, 1'b1, 1'b1, 32'h0040_0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0008, 32'h0040_0008, 1'b1, 1'b1, 32'h0040_0004};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0, 32'h0040_0004};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, JUNK,          32'h0000_0100, 1'b1, 1'b0, 32'h0040_0004};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, JUNK,          32'h0000_0100, 1'b1, 1'b0, 32'h0040_0004}; // ack delay
        tbl[6]  = '{1'b0, 1'b0, 1'b0, JUNK,          32'h0000_0100, 1'b1, 1'b0, 32'h0040_0004};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, JUNK,          32'h0000_0100, 1'b1, 1'b0, 32'h0040_0004};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0100};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, JUNK,          32'h0000_0200, 1'b0, 1'b0, 32'h0000_0100}; // ack+stall
        tbl[10] = '{1'b0, 1'b1, 1'b0, JUNK,          32'h0000_0200, 1'b0, 1'b0, 32'h0000_0100};
        tbl[11] = '{1'b0, 1'b1, 1'b0, JUNK,          32'h0000_0200, 1'b0, 1'b0, 32'h0000_0100};
        tbl[12] = '{1'b0, 1'b1, 1'b0, JUNK,          32'h0000_0200, 1'b0, 1'b0, 32'h0000_0100};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0000_0204, 32'h0000_0204, 1'b1, 1'b1, 32'h0000_0200};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_3000, 1'b0, 1'b0, 32'h0000_0200}; // redirect
        tbl[15] = '{1'b0, 1'b0, 1'b0, JUNK,          32'h0000_3000, 1'b1, 1'b0, 32'h0000_0200};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h0000_3004, 1'b1, 1'b1, 32'h0000_3000};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0, 32'h0000_3000};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h0000_5000, 1'b0, 1'b0, 32'h0000_3000}; // CANCEL reload
        tbl[19] = '{1'b0, 1'b0, 1'b1, JUNK,          32'h0000_5000, 1'b1, 1'b0, 32'h0000_3000};
        tbl[20] = '{1'b0, 1'b1, 1'b1, JUNK,          32'h0000_5000, 1'b0, 1'b0, 32'h0000_3000};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_6000, 1'b0, 1'b0, 32'h0000_3000}; // HOLD redirect
        tbl[22] = '{1'b0, 1'b0, 1'b0, JUNK,          32'h0000_6000, 1'b1, 1'b0, 32'h0000_3000};
    end

    initial begin
        logic r, s, a;
        logic [31:0] n;

        // Power-on reset, checked before any clock edge.
        #1 Reset = 1'b0;
        #2 check_reset_values("por");
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b1;
        model_reset();

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].n);
            chk($sformatf("tbl%0d_pc", i), PCResult, tbl[i].pc);
            chk($sformatf("tbl%0d_req", i), {31'd0, ImemReq}, {31'd0, tbl[i].req});
            chk($sformatf("tbl%0d_fv", i), {31'd0, FetchValid}, {31'd0, tbl[i].fv});
            chk($sformatf("tbl%0d_fpc", i), FetchPC, tbl[i].fpc);
            chk($sformatf("tbl%0d_timeout", i), {31'd0, ImemTimeout}, 32'd0);
        end

        // Watchdog: 14 idle FETCH cycles stay clear, the 15th sets the flag.
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, JUNK);
        chk("wd_before", {31'd0, ImemTimeout}, 32'd0);
        step(1'b0, 1'b0, 1'b0, JUNK);
        chk("wd_set", {31'd0, ImemTimeout}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, JUNK);
        step(1'b0, 1'b0, 1'b1, 32'h0000_6004);
        chk("wd_sticky", {31'd0, ImemTimeout}, 32'd1);
        chk("wd_fetch_continues", FetchPC, 32'h0000_6000);

        // Async reset mid-fetch, between clock edges.
        step(1'b0, 1'b0, 1'b0, JUNK);
        #2 Reset = 1'b0;
        #1 check_reset_values("async");
        @(posedge Clk); #1;
        chk("async_held_fv", {31'd0, FetchValid}, 32'd0);
        Reset = 1'b1;
        model_reset();

        // PC wraparound at the top of the address space.
        step(1'b0, 1'b0, 1'b1, JUNK);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pc", PCResult, 32'hFFFF_FFFC);
        chk("wrap_plus4", PCPlus4, 32'h0000_0000);
        chk("wrap_upper", {28'd0, PCUpper}, 32'd0);

        // Misaligned NextPC.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0102);
`ifdef PC_MISALIGN_TRAP_EN
        chk("align_pc", PCResult, 32'h0000_0100);
        chk("align_err", {31'd0, AlignErr}, 32'd1);
`else
        chk("misalign_pc", PCResult, 32'h0000_0102);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(7) == 0);
            s = ($urandom_range(3) == 0);
            a = ($urandom_range(1) == 0);
            n = ($urandom_range(1) == 0) ? m_pc + 32'd4 : $urandom;
            step(r, s, a, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
